// File: rtl/cirno9_pkg.sv
// cirno9_pkg: shared types and defaults for the cirno9 SRAM arbiter.
// Owner encoding for the one-cycle response path plus SRAM window defaults.
package cirno9_pkg;

   localparam int          CIRNO9_AW   = 14;
   localparam logic [31:0] CIRNO9_BASE = 32'h8000_0000;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_IFU    = 2'd1,
      OWN_LSU_RD = 2'd2,
      OWN_LSU_WR = 2'd3
   } own_kind_t;

   typedef struct packed {
      logic      err;
      own_kind_t kind;
   } own_t;

   localparam own_t OWN_IDLE = '{err: 1'b0, kind: OWN_NONE};

endpackage

// File: rtl/cirno9_arb_perf.sv
// cirno9_arb_perf: grant and conflict counters for the SRAM arbiter.
// Built only when CIRNO9_ARB_PERF_EN is defined; counters wrap.
module cirno9_arb_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_gnt,
   input  logic        lsu_gnt,
   input  logic        conflict,
   output logic [31:0] perf_ifu_gnt,
   output logic [31:0] perf_lsu_gnt,
   output logic [31:0] perf_conflict
);

   // Count grants per port and cycles with both requesters pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_ifu_gnt  <= '0;
         perf_lsu_gnt  <= '0;
         perf_conflict <= '0;
      end else begin
         if (ifu_gnt)  perf_ifu_gnt  <= perf_ifu_gnt + 32'd1;
         if (lsu_gnt)  perf_lsu_gnt  <= perf_lsu_gnt + 32'd1;
         if (conflict) perf_conflict <= perf_conflict + 32'd1;
      end
   end

endmodule

// File: rtl/cirno9_sram_arb.sv
// cirno9_sram_arb: IFU/LSU arbiter for the single-port core SRAM.
// Define CIRNO9_ARB_PERF_EN to build the perf counters; else they read 0.
module cirno9_sram_arb
   import cirno9_pkg::*;
#(
   parameter int          AW         = CIRNO9_AW,
   parameter logic [31:0] BASE       = CIRNO9_BASE,
   parameter int          STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ifu_req_valid,
   output logic          ifu_req_ready,
   input  logic [31:0]   ifu_req_addr,
   output logic          ifu_rsp_valid,
   output logic [31:0]   ifu_rsp_rdata,
   output logic          ifu_rsp_err,
   input  logic          lsu_req_valid,
   output logic          lsu_req_ready,
   input  logic [31:0]   lsu_req_addr,
   input  logic          lsu_req_wen,
   input  logic [3:0]    lsu_req_wstrb,
   input  logic [31:0]   lsu_req_wdata,
   output logic          lsu_rsp_valid,
   output logic [31:0]   lsu_rsp_rdata,
   output logic          lsu_rsp_err,
   output logic          sram_cs,
   output logic          sram_we,
   output logic [3:0]    sram_wem,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata,
   output logic [31:0]   perf_ifu_gnt,
   output logic [31:0]   perf_lsu_gnt,
   output logic [31:0]   perf_conflict
);

   localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;
   own_t          own;
   own_t          own_nxt;
   logic          starved;
   logic          ifu_gnt;
   logic          lsu_gnt;
   logic          g_ok;
   logic [31:0]   g_addr;
   logic          unused_addr;

   assign starved       = ifu_req_valid & (starve_cnt == SMAX);
   assign lsu_req_ready = lsu_req_valid & ~starved;
   assign ifu_req_ready = ifu_req_valid & ~lsu_req_ready;
   assign lsu_gnt       = lsu_req_ready;
   assign ifu_gnt       = ifu_req_ready;

   assign g_addr      = lsu_gnt ? lsu_req_addr : ifu_req_addr;
   assign g_ok        = g_addr[31:AW+2] == BASE[31:AW+2];
   assign unused_addr = ^g_addr[1:0];

   assign sram_cs    = (lsu_gnt | ifu_gnt) & g_ok;
   assign sram_we    = sram_cs & lsu_gnt & lsu_req_wen;
   assign sram_wem   = sram_we ? lsu_req_wstrb : 4'b0000;
   assign sram_addr  = g_addr[AW+1:2];
   assign sram_wdata = lsu_req_wdata;

   // Classify this cycle's grant for the response next cycle.
   always_comb begin
      own_nxt = OWN_IDLE;
      unique case (1'b1)
         lsu_gnt: begin
            own_nxt.err  = ~g_ok;
            own_nxt.kind = lsu_req_wen ? OWN_LSU_WR : OWN_LSU_RD;
         end
         ifu_gnt: begin
            own_nxt.err  = ~g_ok;
            own_nxt.kind = OWN_IFU;
         end
         default: own_nxt = OWN_IDLE;
      endcase
   end

   // Response owner and IFU starvation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own        <= OWN_IDLE;
         starve_cnt <= '0;
      end else begin
         own <= own_nxt;
         if (ifu_req_valid & ~ifu_req_ready)
            starve_cnt <= (starve_cnt == SMAX) ? SMAX : starve_cnt + 1'b1;
         else
            starve_cnt <= '0;
      end
   end

   assign ifu_rsp_valid = own.kind == OWN_IFU;
   assign ifu_rsp_err   = ifu_rsp_valid & own.err;
   assign ifu_rsp_rdata = (ifu_rsp_valid & ~own.err) ? sram_rdata : '0;

   assign lsu_rsp_valid = (own.kind == OWN_LSU_RD) | (own.kind == OWN_LSU_WR);
   assign lsu_rsp_err   = lsu_rsp_valid & own.err;
   assign lsu_rsp_rdata = ((own.kind == OWN_LSU_RD) & ~own.err) ? sram_rdata : '0;

`ifdef CIRNO9_ARB_PERF_EN
   cirno9_arb_perf u_perf (
      .clk           (clk),
      .rst           (rst),
      .ifu_gnt       (ifu_gnt),
      .lsu_gnt       (lsu_gnt),
      .conflict      (ifu_req_valid & lsu_req_valid),
      .perf_ifu_gnt  (perf_ifu_gnt),
      .perf_lsu_gnt  (perf_lsu_gnt),
      .perf_conflict (perf_conflict)
   );
`else
   assign perf_ifu_gnt  = '0;
   assign perf_lsu_gnt  = '0;
   assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_cirno9_sram_arb.sv
// tb_cirno9_sram_arb: scoreboard bench for the cirno9 SRAM arbiter.
// Expected responses are queued at grant time and popped one cycle later.
module tb_cirno9_sram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_rsp_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
   logic [31:0] lsu_req_addr, lsu_req_wdata;
   logic [3:0]  lsu_req_wstrb;
   logic        lsu_rsp_valid, lsu_rsp_err;
   logic [31:0] lsu_rsp_rdata;
   logic        sram_cs, sram_we;
   logic [3:0]  sram_wem;
   logic [13:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata;
   logic [31:0] perf_ifu_gnt, perf_lsu_gnt, perf_conflict;

   logic [31:0] mem [0:16383];
   logic [67:0] rsp;
   logic [19:0] sram_ctl;
   logic [95:0] perf_all;
   logic [67:0] sb [$];
   logic [67:0] e;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   assign rsp      = {ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata,
                      lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata};
   assign sram_ctl = {sram_cs, sram_we, sram_wem, sram_addr};
   assign perf_all = {perf_ifu_gnt, perf_lsu_gnt, perf_conflict};

   cirno9_sram_arb dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_rdata (ifu_rsp_rdata),
      .ifu_rsp_err   (ifu_rsp_err),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_req_addr  (lsu_req_addr),
      .lsu_req_wen   (lsu_req_wen),
      .lsu_req_wstrb (lsu_req_wstrb),
      .lsu_req_wdata (lsu_req_wdata),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rsp_rdata (lsu_rsp_rdata),
      .lsu_rsp_err   (lsu_rsp_err),
      .sram_cs       (sram_cs),
      .sram_we       (sram_we),
      .sram_wem      (sram_wem),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .perf_ifu_gnt  (perf_ifu_gnt),
      .perf_lsu_gnt  (perf_lsu_gnt),
      .perf_conflict (perf_conflict)
   );

   // SRAM macro model: byte-masked write, read data one cycle later.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we)
            for (int b = 0; b < 4; b++)
               if (sram_wem[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         sram_rdata <= mem[sram_addr];
      end
   end

   function automatic logic [67:0] rsp_ifu(input logic [31:0] d, input logic er);
      return {1'b1, er, d, 1'b0, 1'b0, 32'h0};
   endfunction

   function automatic logic [67:0] rsp_lsu(input logic [31:0] d, input logic er);
      return {1'b0, 1'b0, 32'h0, 1'b1, er, d};
   endfunction

   task automatic set_ifu(input logic v, input logic [31:0] a);
      ifu_req_valid = v;
      ifu_req_addr  = a;
   endtask

   task automatic set_lsu(input logic v, input logic [31:0] a, input logic w,
                          input logic [3:0] s, input logic [31:0] d);
      lsu_req_valid = v;
      lsu_req_addr  = a;
      lsu_req_wen   = w;
      lsu_req_wstrb = s;
      lsu_req_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_ifu(1'b0, 32'h0);
      set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      repeat (2) @(negedge clk);
      total++;
      if (rsp !== 68'h0) begin
         bad++; $display("FAIL reset_rsp got=%h want=0", rsp);
      end
      total++;
      if ({ifu_req_ready, lsu_req_ready, sram_ctl} !== 22'h0) begin
         bad++; $display("FAIL reset_port got=%h want=0", {ifu_req_ready, lsu_req_ready, sram_ctl});
      end
      total++;
      if (perf_all !== 96'h0) begin
         bad++; $display("FAIL reset_perf got=%h want=0", perf_all);
      end
      rst = 1'b0;
   endtask

   task automatic test_lsu_write();
      logic [31:0] a [5];
      logic [3:0]  s [5];
      logic [31:0] d [5];
      logic [13:0] w [5];
      a = '{32'h8000_0010, 32'h8000_0000, 32'h8000_0020, 32'h8000_0020, 32'h8000_FFFC};
      s = '{4'hF, 4'hF, 4'hF, 4'b0011, 4'hF};
      d = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hAAAA_AAAA, 32'h1234_5678, 32'hCAFE_F00D};
      w = '{14'd4, 14'd0, 14'd8, 14'd8, 14'h3FFF};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            total++;
            if (rsp !== e) begin
               bad++; $display("FAIL wr_rsp%0d got=%h want=%h", i - 1, rsp, e);
            end
         end
         set_lsu(1'b1, a[i], 1'b1, s[i], d[i]);
         #1;
         total++;
         if ({lsu_req_ready, ifu_req_ready, sram_ctl, sram_wdata} !==
             {1'b1, 1'b0, 1'b1, 1'b1, s[i], w[i], d[i]}) begin
            bad++;
            $display("FAIL wr_port%0d got=%h want=%h", i,
                     {lsu_req_ready, ifu_req_ready, sram_ctl, sram_wdata},
                     {1'b1, 1'b0, 1'b1, 1'b1, s[i], w[i], d[i]});
         end
         sb.push_back(rsp_lsu(32'h0, 1'b0));
      end
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (rsp !== e) begin
         bad++; $display("FAIL wr_rsp4 got=%h want=%h", rsp, e);
      end
      set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      #1;
      total++;
      if ({sram_cs, sram_we} !== 2'b00) begin
         bad++; $display("FAIL idle_cs got=%b want=00", {sram_cs, sram_we});
      end
   endtask

   task automatic test_reads();
      logic        isi [5];
      logic [31:0] a [5];
      logic [13:0] w [5];
      logic [31:0] d [5];
      isi = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      a = '{32'h8000_0010, 32'h8000_0020, 32'h8000_0023, 32'h8000_FFFC, 32'h8000_0000};
      w = '{14'd4, 14'd8, 14'd8, 14'h3FFF, 14'd0};
      d = '{32'hDEAD_BEEF, 32'hAAAA_5678, 32'hAAAA_5678, 32'hCAFE_F00D, 32'h0BAD_F00D};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            total++;
            if (rsp !== e) begin
               bad++; $display("FAIL rd_rsp%0d got=%h want=%h", i - 1, rsp, e);
            end
         end
         if (i == 5) begin
            set_ifu(1'b0, 32'h0);
            set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
         end else begin
            set_ifu(isi[i], a[i]);
            set_lsu(!isi[i], a[i], 1'b0, 4'h0, 32'h0);
            #1;
            total++;
            if ({lsu_req_ready, ifu_req_ready, sram_ctl} !==
                {!isi[i], isi[i], 1'b1, 1'b0, 4'h0, w[i]}) begin
               bad++;
               $display("FAIL rd_port%0d got=%h want=%h", i,
                        {lsu_req_ready, ifu_req_ready, sram_ctl},
                        {!isi[i], isi[i], 1'b1, 1'b0, 4'h0, w[i]});
            end
            sb.push_back(isi[i] ? rsp_ifu(d[i], 1'b0) : rsp_lsu(d[i], 1'b0));
         end
      end
   endtask

   task automatic test_window();
      logic        iv [7];
      logic [31:0] ia [7];
      logic        lv [7];
      logic [31:0] la [7];
      logic        lw [7];
      logic [2:0]  ex [7];
      logic [67:0] er [7];
      iv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      ia = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0010, 32'h0, 32'h8000_FFFC};
      lv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      la = '{32'h9000_0000, 32'h0, 32'h8001_0000, 32'h7FFF_FFFC, 32'h0, 32'h8000_0000, 32'h0};
      lw = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ex = '{3'b100, 3'b011, 3'b100, 3'b100, 3'b010, 3'b101, 3'b011};
      er = '{rsp_lsu(32'h0, 1'b1), rsp_ifu(32'h0BAD_F00D, 1'b0),
             rsp_lsu(32'h0, 1'b1), rsp_lsu(32'h0, 1'b1),
             rsp_ifu(32'h0, 1'b1), rsp_lsu(32'h0BAD_F00D, 1'b0),
             rsp_ifu(32'hCAFE_F00D, 1'b0)};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            total++;
            if (rsp !== e) begin
               bad++; $display("FAIL win_rsp%0d got=%h want=%h", i - 1, rsp, e);
            end
         end
         if (i == 7) begin
            set_ifu(1'b0, 32'h0);
            set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
         end else begin
            set_ifu(iv[i], ia[i]);
            set_lsu(lv[i], la[i], lw[i], 4'hF, 32'h5555_5555);
            #1;
            total++;
            if ({lsu_req_ready, ifu_req_ready, sram_cs, sram_we} !== {ex[i], 1'b0}) begin
               bad++;
               $display("FAIL win_port%0d got=%b want=%b", i,
                        {lsu_req_ready, ifu_req_ready, sram_cs, sram_we}, {ex[i], 1'b0});
            end
            sb.push_back(er[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  pat;
      logic [95:0] pexp;
`ifdef CIRNO9_ARB_PERF_EN
      pexp = {32'd2, 32'd6, 32'd8};
`else
      pexp = 96'h0;
`endif
      pat = 8'b1000_1000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) begin
            e = sb.pop_front();
            total++;
            if (rsp !== e) begin
               bad++; $display("FAIL b2b_rsp%0d got=%h want=%h", i - 1, rsp, e);
            end
         end
         if (i == 8) begin
            total++;
            if (perf_all !== pexp) begin
               bad++; $display("FAIL perf got=%h want=%h", perf_all, pexp);
            end
            set_ifu(1'b0, 32'h0);
            set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
         end else begin
            set_ifu(1'b1, 32'h8000_0010);
            set_lsu(1'b1, 32'h8000_0040, 1'b1, 4'hF, 32'h1111_1111);
            #1;
            total++;
            if ({ifu_req_ready, lsu_req_ready, sram_we, sram_addr} !==
                {pat[i], !pat[i], !pat[i], pat[i] ? 14'd4 : 14'd16}) begin
               bad++;
               $display("FAIL b2b_gnt%0d got=%h want=%h", i,
                        {ifu_req_ready, lsu_req_ready, sram_we, sram_addr},
                        {pat[i], !pat[i], !pat[i], pat[i] ? 14'd4 : 14'd16});
            end
            sb.push_back(pat[i] ? rsp_ifu(32'hDEAD_BEEF, 1'b0) : rsp_lsu(32'h0, 1'b0));
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] pat;
      pat = 4'b1000;
      @(negedge clk);
      set_ifu(1'b1, 32'h8000_0010);
      #1;
      total++;
      if (ifu_req_ready !== 1'b1) begin
         bad++; $display("FAIL mid_gnt got=%b want=1", ifu_req_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      set_ifu(1'b0, 32'h0);
      @(negedge clk);
      total++;
      if ({rsp, ifu_req_ready, lsu_req_ready, sram_ctl} !== 90'h0) begin
         bad++; $display("FAIL mid_rst_out got=%h want=0", {rsp, ifu_req_ready, lsu_req_ready, sram_ctl});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (rsp !== 68'h0) begin
         bad++; $display("FAIL mid_late_rsp got=%h want=0", rsp);
      end
      set_ifu(1'b1, 32'h8000_0010);
      set_lsu(1'b1, 32'h8000_0040, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (rsp !== 68'h0) begin
         bad++; $display("FAIL mid_drop got=%h want=0", rsp);
      end
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         #1;
         total++;
         if ({ifu_req_ready, lsu_req_ready} !== {pat[j], !pat[j]}) begin
            bad++;
            $display("FAIL mid_starve%0d got=%b want=%b", j,
                     {ifu_req_ready, lsu_req_ready}, {pat[j], !pat[j]});
         end
      end
      @(negedge clk);
      set_ifu(1'b0, 32'h0);
      set_lsu(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lsu_write();
      test_reads();
      test_window();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
